// File: rtl/tpu_host_sequencer.sv
// tpu_host_sequencer: drives one 2x2 A/B job into the matrix controller's byte-serial
// load port, waits for done (with timeout), reads C back and returns it packed.
module tpu_host_sequencer #(
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [4*DATA_W-1:0] cmd_a,
  input  logic [4*DATA_W-1:0] cmd_b,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [4*DATA_W-1:0] res_c,
  output logic                busy,
  output logic                timeout_err,
  output logic                load_en,
  output logic                load_sel_ab,
  output logic [1:0]          load_index,
  output logic [DATA_W-1:0]   load_data,
  output logic                output_en,
  output logic [1:0]          output_sel,
  input  logic [DATA_W-1:0]   out_data,
  input  logic                done
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int CW = TW > 3 ? TW : 3;
  typedef enum logic [2:0] {IDLE, LOAD, WAIT_DONE, READ, RESP} state_t;
  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [8*DATA_W-1:0] ab_q, ab_d;
  logic [4*DATA_W-1:0] res_c_q, res_c_d;
  logic [DATA_W-1:0]   load_data_q, load_data_d;
  logic [1:0]          load_index_q, load_index_d, output_sel_q, output_sel_d;
  logic                load_en_q, load_en_d, load_sel_ab_q, load_sel_ab_d;
  logic                output_en_q, output_en_d, res_valid_q, res_valid_d;
  logic                busy_q, busy_d, timeout_err_q, timeout_err_d, accept;

  assign cmd_ready   = state_q == IDLE;
  assign accept      = cmd_ready && cmd_valid;
  assign res_valid   = res_valid_q;
  assign res_c       = res_c_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;
  assign load_en     = load_en_q;
  assign load_sel_ab = load_sel_ab_q;
  assign load_index  = load_index_q;
  assign load_data   = load_data_q;
  assign output_en   = output_en_q;
  assign output_sel  = output_sel_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      ab_q          <= '0;
      res_c_q       <= '0;
      load_data_q   <= '0;
      load_index_q  <= '0;
      output_sel_q  <= '0;
      load_en_q     <= 1'b0;
      load_sel_ab_q <= 1'b0;
      output_en_q   <= 1'b0;
      res_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ab_q          <= ab_d;
      res_c_q       <= res_c_d;
      load_data_q   <= load_data_d;
      load_index_q  <= load_index_d;
      output_sel_q  <= output_sel_d;
      load_en_q     <= load_en_d;
      load_sel_ab_q <= load_sel_ab_d;
      output_en_q   <= output_en_d;
      res_valid_q   <= res_valid_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // One counter serves load beats, the done timer and readout; it restarts on every state change.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (cmd_valid) state_d = LOAD;
      LOAD:      if (cnt_q[2:0] == 3'd7) state_d = WAIT_DONE;
      WAIT_DONE: state_d = done ? READ : (cnt_q == CW'(TIMEOUT_CYCLES - 1)) ? IDLE : WAIT_DONE;
      READ:      if (cnt_q[1:0] == 2'd3) state_d = RESP;
      RESP:      if (res_ready) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    cnt_d = (state_d == state_q && state_q != IDLE && state_q != RESP) ? cnt_q + 1'b1 : '0;
  end

  // Outputs are registered from the next state so beat 0 appears the cycle after accept.
  always_comb begin
    ab_d          = accept ? {cmd_b, cmd_a} : ab_q;
    load_en_d     = state_d == LOAD;
    load_sel_ab_d = load_en_d & cnt_d[2];
    load_index_d  = load_en_d ? cnt_d[1:0] : 2'b00;
    load_data_d   = load_en_d ? ab_d[DATA_W*int'(cnt_d[2:0]) +: DATA_W] : '0;
    output_en_d   = state_d == READ;
    output_sel_d  = output_en_d ? cnt_d[1:0] : 2'b00;
    res_valid_d   = state_d == RESP;
    busy_d        = state_d != IDLE;
    timeout_err_d = accept ? 1'b0 : (state_q == WAIT_DONE && state_d == IDLE) ? 1'b1 : timeout_err_q;
    res_c_d       = accept ? '0 : res_c_q;
    if (state_q == READ) res_c_d[DATA_W*int'(cnt_q[1:0]) +: DATA_W] = out_data;
  end
endmodule

// File: tb/tb_tpu_host_sequencer.sv
// tb_tpu_host_sequencer: directed bench with a small matrix-controller model behind the load/readout ports.
module tb_tpu_host_sequencer;
  logic        clk = 1'b0, rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, res_valid, res_ready = 1'b0;
  logic [31:0] cmd_a = '0, cmd_b = '0, res_c;
  logic        busy, timeout_err, load_en, load_sel_ab, output_en, done = 1'b0;
  logic [1:0]  load_index, output_sel;
  logic [7:0]  load_data, out_data;
  logic [7:0]  m [8];
  int          n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  tpu_host_sequencer #(.DATA_W(8), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .res_valid(res_valid), .res_ready(res_ready),
    .res_c(res_c), .busy(busy), .timeout_err(timeout_err), .load_en(load_en),
    .load_sel_ab(load_sel_ab), .load_index(load_index), .load_data(load_data),
    .output_en(output_en), .output_sel(output_sel), .out_data(out_data), .done(done)
  );

  initial for (int i = 0; i < 8; i++) m[i] = '0;

  always @(posedge clk) if (load_en) m[{load_sel_ab, load_index}] <= load_data;

  // Controller model: C[r][c] = A[r][0]*B[0][c] + A[r][1]*B[1][c], truncated to 8 bits.
  always_comb begin
    logic [7:0] p0, p1;
    p0 = m[{1'b0, output_sel[1], 1'b0}] * m[{2'b10, output_sel[0]}];
    p1 = m[{1'b0, output_sel[1], 1'b1}] * m[{2'b11, output_sel[0]}];
    out_data = p0 + p1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_job(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_c,
                         input int bp, input bit spurious, input bit hold);
    logic [63:0] ab;
    ab = {b, a};
    cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    tick();
    if (!hold) cmd_valid = 1'b0;
    check("err_cleared", timeout_err, 0);
    check("res_c_cleared", res_c, 0);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("load_en%0d", k), load_en, 1);
      check($sformatf("load_sel%0d", k), {load_sel_ab, load_index}, k);
      check($sformatf("load_data%0d", k), load_data, ab[8*k +: 8]);
      if (!hold) cmd_valid = spurious && k == 2;
      if (k == 2) cmd_a = 32'hFFFFFFFF;
      done = spurious && k == 3;
      tick();
    end
    done = 1'b0;
    check("load_off", load_en, 0);
    check("wait_busy", busy, 1);
    check("wait_ready", cmd_ready, 0);
    repeat (3) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    for (int j = 0; j < 4; j++) begin
      check($sformatf("oen%0d", j), output_en, 1);
      check($sformatf("osel%0d", j), output_sel, j);
      done = spurious && j == 1;
      tick();
    end
    done = 1'b0;
    res_ready = bp == 0;
    check("res_valid", res_valid, 1);
    check("res_c", res_c, exp_c);
    check("resp_ready", cmd_ready, 0);
    check("resp_noload", load_en, 0);
    for (int i = 0; i < bp; i++) begin
      tick();
      check("bp_valid", res_valid, 1);
      check("bp_res_c", res_c, exp_c);
      check("bp_ready", cmd_ready, 0);
      check("bp_noload", load_en, 0);
    end
    res_ready = 1'b1;
    tick();
    check("post_valid", res_valid, 0);
    check("post_ready", cmd_ready, 1);
    check("post_err", timeout_err, 0);
    check("post_res_c", res_c, exp_c);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_load", load_en, 0);
    check("rst_oen", output_en, 0);
    check("rst_valid", res_valid, 0);
    check("rst_res_c", res_c, 0);
    check("rst_err", timeout_err, 0);
    rst = 1'b0;
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    check("idle_done_busy", busy, 0);
    check("idle_done_err", timeout_err, 0);
    check("idle_done_valid", res_valid, 0);
    run_job(32'h04030201, 32'h08070605, 32'h322B1613, 0, 1'b0, 1'b0);
    run_job(32'h04030201, 32'h08070605, 32'h322B1613, 10, 1'b0, 1'b0);
    run_job(32'h04030201, 32'h08070605, 32'h322B1613, 0, 1'b1, 1'b0);
    check("spur_busy", busy, 0);
    // timeout: no done ever
    cmd_a = 32'h04030201; cmd_b = 32'h08070605; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    repeat (8) tick();
    for (int i = 0; i < 8; i++) begin
      check($sformatf("to_wait%0d", i), timeout_err, 0);
      check($sformatf("to_busy%0d", i), busy, 1);
      tick();
    end
    check("to_err", timeout_err, 1);
    check("to_idle", cmd_ready, 1);
    check("to_busy", busy, 0);
    check("to_novalid", res_valid, 0);
    tick();
    check("to_sticky", timeout_err, 1);
    check("to_novalid2", res_valid, 0);
    // back-to-back with cmd_valid held high across the first handshake
    run_job(32'h04030201, 32'h08070605, 32'h322B1613, 3, 1'b0, 1'b1);
    run_job(32'h01000001, 32'h0D0C0B0A, 32'h0D0C0B0A, 0, 1'b0, 1'b0);
    // reset during load beat 5
    cmd_a = 32'h04030201; cmd_b = 32'h08070605; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    repeat (5) tick();
    check("pre_rst_beat5", {load_sel_ab, load_index}, 5);
    rst = 1'b1;
    #1;
    check("mid_rst_load", load_en, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", cmd_ready, 1);
    check("mid_rst_data", load_data, 0);
    tick();
    rst = 1'b0;
    tick();
    check("after_rst_load", load_en, 0);
    check("after_rst_valid", res_valid, 0);
    run_job(32'h04030201, 32'h08070605, 32'h322B1613, 0, 1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/tpu_host_sequencer.md
Name: tpu_host_sequencer

Overview:
- Host-side initiator for the matrix controller's byte-serial load/readout interface.
- Accepts one 2x2 A / 2x2 B job on a valid/ready command port and streams the 8 operand bytes into the controller's load port.
- Waits for the done handshake (with timeout), reads the 4 C elements back through output_en/output_sel, and returns them packed on a valid/ready result port.
- Sits between a test or host interface and the matrix controller, so the TPU can be driven by a single command word.

Parameters:
- DATA_W, 8, element width in bits.
- TIMEOUT_CYCLES, 64, maximum number of WAIT_DONE cycles before abort; must be >= 2.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- cmd_valid  in  1  job offered.
- cmd_ready  out  1  sequencer idle and able to accept a job.
- cmd_a  in  4*DATA_W  A elements; element i in bits [DATA_W*i +: DATA_W]; i = row*2 + col.
- cmd_b  in  4*DATA_W  B elements, same packing as cmd_a.
- res_valid  out  1  result available.
- res_ready  in  1  result consumed.
- res_c  out  4*DATA_W  C elements, same packing as cmd_a.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  sticky; set when the last job aborted on timeout.
- load_en  out  1  to controller load enable.
- load_sel_ab  out  1  to controller; 0 selects A, 1 selects B.
- load_index  out  2  to controller element index.
- load_data  out  DATA_W  to controller in_data.
- output_en  out  1  to controller readout enable.
- output_sel  out  2  to controller readout index.
- out_data  in  DATA_W  from controller; combinational, valid in the same cycle output_sel is driven.
- done  in  1  from controller completion signal.

Behaviour:
- One clock domain. Reset is asynchronous, active-high.
- On reset:
  - State is IDLE and all counters are 0.
  - All controller-side outputs, res_valid, res_c, busy and timeout_err are 0.
  - cmd_ready is 1, because it is decoded from state == IDLE.
- All outputs except cmd_ready are registered.
- States are IDLE, LOAD, WAIT_DONE, READ, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid && cmd_ready (accept edge T): capture cmd_a/cmd_b, clear timeout_err, clear res_c, go to LOAD.
- LOAD:
  - Runs for 8 consecutive cycles, T+1 through T+8.
  - Beat k (0..7) drives load_en=1, load_sel_ab=k[2], load_index=k[1:0], and the corresponding captured byte on load_data.
  - Order is A0, A1, A2, A3, B0, B1, B2, B3.
  - After beat 7, load_en drops to 0 and the state goes to WAIT_DONE.
- WAIT_DONE:
  - Controller outputs are all 0. A timer counts from 0.
  - The first cycle in which done=1 is sampled moves the state to READ.
  - If the timer reaches TIMEOUT_CYCLES-1 with done=0: set timeout_err=1, go to IDLE, and do not assert res_valid.
  - If done and the timeout coincide, done wins.
- done is ignored in every other state. A spurious done has no effect and sets no flag.
- READ:
  - Runs for 4 cycles. Cycle j (0..3) drives output_en=1, output_sel=j.
  - At the end of cycle j, out_data is registered into the res_c slot j.
  - Then go to RESP with output_en=0.
- RESP:
  - res_valid=1 and res_c is held stable.
  - On res_ready=1, drop res_valid and go to IDLE.
  - res_ready asserted outside RESP is ignored.
- Latency:
  - Accept at T gives the first load beat at T+1.
  - A done sampled at cycle D gives res_valid high from D+5.
  - With res_ready tied high, cmd_ready is 1 again at D+6.
- cmd_valid is ignored while busy. cmd_a/cmd_b may change freely after the accept edge.
- Reset asserted mid-job aborts immediately. All outputs return to reset values, with no partial load completion and no res_valid.
- No arithmetic is done in this block. Data passes through unmodified, DATA_W bits per element.

Test Plan:
- Basic job: cmd_a=32'h04030201, cmd_b=32'h08070605 (A=[1,2;3,4], B=[5,6;7,8]), res_ready=1 -> exactly 8 load beats in order A0..B3 with data 1..8; res_c=32'h322B1613 (C=[19,22;43,50]); res_valid is high for 1 cycle.
- Backpressure: same job with res_ready=0 for 10 cycles after res_valid rises -> res_valid and res_c held unchanged and cmd_ready=0 throughout; after res_ready=1, cmd_ready=1 the next cycle.
- Timeout: model controller that never asserts done, TIMEOUT_CYCLES=8 -> timeout_err=1 exactly 8 cycles after entering WAIT_DONE, back to IDLE, no res_valid; the next accepted job clears timeout_err.
- Back-to-back: two jobs with cmd_valid held high, second job A=identity (32'h01000001), B=32'h0D0C0B0A -> second res_c=32'h0D0C0B0A; no load beat is issued before the first result handshake completes.
- Spurious done and ignored handshakes: done pulsed in IDLE, in LOAD beat 3, and in READ -> no state change and no error; cmd_valid pulsed during LOAD -> ignored.
- Reset mid-job: assert rst during LOAD beat 5 -> load_en=0, busy=0, cmd_ready=1 immediately (asynchronous); a fresh job after release completes correctly.
